// File: rtl/ws2812_tx.sv
// Multi-channel WS2812 serial transmitter: streams 24-bit GRB pixels onto CHANNELS
// lines in lock-step, inserts the latch gap at frame end and flags stream starvation.
module ws2812_tx #(
  parameter int F_CLK    = 12_000_000,
  parameter int CHANNELS = 1,
  parameter int RESET_US = 60
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [24*CHANNELS-1:0]  pix_data,
  input  logic                    pix_valid,
  input  logic                    pix_last,
  output logic                    pix_ready,
  output logic [CHANNELS-1:0]     dout,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    underrun
);

  localparam int BIT_CYC = F_CLK / 800_000;
  localparam int T0H_CYC = F_CLK / 2_500_000;
  localparam int T1H_CYC = F_CLK / 1_250_000;
  localparam int RST_CYC = (F_CLK / 1_000_000) * RESET_US;
  localparam int CW      = $clog2(BIT_CYC);
  localparam int GW      = $clog2(RST_CYC + 1);

  localparam logic [CW-1:0] C_BIT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] C_T0H      = CW'(T0H_CYC);
  localparam logic [CW-1:0] C_T1H      = CW'(T1H_CYC);
  localparam logic [GW-1:0] C_GAP_LAST = GW'(RST_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  if (T0H_CYC < 1 || T1H_CYC >= BIT_CYC || CHANNELS < 1) begin : g_cfg_err
    $fatal(1, "ws2812_tx: invalid timing or channel configuration");
  end

  logic [1:0]              r_state, w_state_next;
  logic [24*CHANNELS-1:0]  r_shift, w_shift_next, w_shift_adv;
  logic                    r_last, w_last_next;
  logic [CW-1:0]           r_cnt, w_cnt_next;
  logic [4:0]              r_bit, w_bit_next;
  logic [GW-1:0]           r_gap, w_gap_next;
  logic [CHANNELS-1:0]     r_dout, w_dout_next;
  logic                    r_busy, r_frame_done, r_underrun, w_underrun_next;
  logic                    w_pix_end, w_xfer;

  // Ready in the final cycle of a non-last pixel lets the next word follow with no gap.
  assign w_pix_end = (r_cnt == C_BIT_LAST) && (r_bit == 5'd0);
  assign pix_ready = (r_state == S_IDLE) || (r_state == S_STALL) ||
                     ((r_state == S_SEND) && w_pix_end && !r_last);
  assign w_xfer    = pix_valid && pix_ready;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign w_shift_adv[gi*24 +: 24] = {r_shift[gi*24 +: 23], 1'b0};
    assign w_dout_next[gi] = (w_state_next == S_SEND) &&
                             (w_cnt_next < (w_shift_next[gi*24+23] ? C_T1H : C_T0H));
  end

  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_last_next     = r_last;
    w_cnt_next      = r_cnt;
    w_bit_next      = r_bit;
    w_gap_next      = r_gap;
    w_underrun_next = 1'b0;
    if (w_xfer) begin
      w_state_next = S_SEND;
      w_shift_next = pix_data;
      w_last_next  = pix_last;
      w_cnt_next   = '0;
      w_bit_next   = 5'd23;
    end else begin
      case (r_state)
        S_SEND: begin
          if (r_cnt != C_BIT_LAST) begin
            w_cnt_next = r_cnt + 1'b1;
          end else begin
            w_cnt_next = '0;
            if (r_bit != 5'd0) begin
              w_bit_next   = r_bit - 1'b1;
              w_shift_next = w_shift_adv;
            end else begin
              w_gap_next   = '0;
              w_state_next = r_last ? S_LATCH : S_STALL;
            end
          end
        end
        S_STALL: begin
          if (r_gap == C_GAP_LAST) begin
            w_state_next    = S_IDLE;
            w_underrun_next = 1'b1;
          end else begin
            w_gap_next = r_gap + 1'b1;
          end
        end
        S_LATCH: begin
          if (r_gap == C_GAP_LAST) w_state_next = S_IDLE;
          else                     w_gap_next   = r_gap + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_last       <= 1'b0;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_gap        <= '0;
      r_dout       <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_shift      <= w_shift_next;
      r_last       <= w_last_next;
      r_cnt        <= w_cnt_next;
      r_bit        <= w_bit_next;
      r_gap        <= w_gap_next;
      r_dout       <= w_dout_next;
      r_busy       <= (w_state_next != S_IDLE);
      r_frame_done <= (w_state_next == S_LATCH) && (w_gap_next == C_GAP_LAST);
      r_underrun   <= w_underrun_next;
    end
  end

  assign dout       = r_dout;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_ws2812_tx.sv
// Bench for ws2812_tx: a 1-channel and a 2-channel instance share one pixel stream and are
// checked every cycle against a waveform-queue model, plus hand-computed totals and timings.
module tb_ws2812_tx;
  localparam int BIT = 15;
  localparam int T0H = 4;
  localparam int T1H = 9;
  localparam int RST = 720;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_last = 1'b0;
  logic        rdy1, rdy2, busy1, busy2, fd1, fd2, ur1, ur2;
  logic [0:0]  d1;
  logic [1:0]  d2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hi_a = 0, hi_b0 = 0, hi_b1 = 0, busy_n = 0, fd_n = 0, ur_n = 0;
  int fd_cyc = -100000, ur_cyc = -100000;

  ws2812_tx #(.F_CLK(12_000_000), .CHANNELS(1), .RESET_US(60)) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_data(pix_data[23:0]), .pix_valid(pix_valid),
    .pix_last(pix_last), .pix_ready(rdy1), .dout(d1), .busy(busy1),
    .frame_done(fd1), .underrun(ur1));

  ws2812_tx #(.F_CLK(12_000_000), .CHANNELS(2), .RESET_US(60)) dut2 (
    .clk(clk), .rst_n(rst_n), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_last(pix_last), .pix_ready(rdy2), .dout(d2), .busy(busy2),
    .frame_done(fd2), .underrun(ur2));

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Model: a queue holds the remaining line levels of the pixel in flight.
  logic [1:0] wq[$];
  int         m_mode = 0;  // 0 idle, 1 sending, 2 starved, 3 latch gap
  bit         m_last = 1'b0;
  int         m_cnt = 0;
  logic [1:0] e_dout = '0;
  bit         e_busy = 1'b0, e_fd = 1'b0, e_ur = 1'b0;

  function automatic bit m_ready();
    return (m_mode == 0) || (m_mode == 2) || (m_mode == 1 && wq.size() == 0 && !m_last);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      wq.delete();
      m_mode = 0; m_last = 1'b0; m_cnt = 0;
      e_dout = '0; e_busy = 1'b0; e_fd = 1'b0; e_ur = 1'b0;
    end else begin
      e_fd = 1'b0;
      e_ur = 1'b0;
      if (pix_valid && m_ready()) begin
        wq.delete();
        for (int b = 23; b >= 0; b--)
          for (int c = 0; c < BIT; c++)
            wq.push_back({c < (pix_data[24+b] ? T1H : T0H), c < (pix_data[b] ? T1H : T0H)});
        m_last = pix_last;
        m_mode = 1;
      end else begin
        case (m_mode)
          1: if (wq.size() == 0) begin m_mode = m_last ? 3 : 2; m_cnt = 0; end
          2: begin m_cnt++; if (m_cnt == RST) begin m_mode = 0; e_ur = 1'b1; end end
          3: begin m_cnt++; if (m_cnt == RST) m_mode = 0; end
          default: ;
        endcase
      end
      if (m_mode == 3 && m_cnt == RST - 1) e_fd = 1'b1;
      e_dout = (m_mode == 1) ? wq.pop_front() : 2'b00;
      e_busy = (m_mode != 0);
    end
  end

  initial forever begin
    logic [10:0] got, exp;
    bit mr;
    @(negedge clk);
    mr  = m_ready();
    got = {d1, d2, busy1, busy2, fd1, fd2, ur1, ur2, rdy1, rdy2};
    exp = {e_dout[0], e_dout, e_busy, e_busy, e_fd, e_fd, e_ur, e_ur, mr, mr};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL cycle_compare cyc=%0d got=%b expected=%b (d1,d2[1:0],busy x2,fd x2,ur x2,rdy x2)",
               cyc, got, exp);
    end
    if (rst_n) begin
      hi_a   += int'(d1[0]);
      hi_b0  += int'(d2[0]);
      hi_b1  += int'(d2[1]);
      busy_n += int'(busy1);
      if (fd1) begin fd_n++; fd_cyc = cyc; end
      if (ur1) begin ur_n++; ur_cyc = cyc; end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
    else $display("check %s = %0d ok", name, got);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one word and returns the cycle number on which it was accepted.
  task automatic send(input logic [47:0] d, input bit last, input bit keep, output int tx);
    pix_data = d; pix_last = last; pix_valid = 1'b1; tx = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rdy1) begin tx = cyc; break; end
    end
    if (tx < 0) begin
      checks++; failures++;
      $display("FAIL send_timeout data=%h got=no_accept expected=accept", d);
    end
    @(posedge clk); #1;
    if (!keep) begin pix_valid = 1'b0; pix_last = 1'b0; end
    $display("xfer data=%h last=%0d cyc=%0d", d, last, tx);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!busy1) begin done = 1'b1; break; end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL idle_timeout got=busy expected=idle");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int tx, tx2, s_hi, s_b0, s_b1, s_busy, s_fd, s_ur;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", int'(rdy1), 1);
    chk("reset_busy", int'(busy1), 0);
    chk("reset_dout", int'(d2), 0);
    step(2);

    s_hi = hi_a; s_busy = busy_n; s_fd = fd_n;
    send(48'h000000_FF0000, 1'b1, 1'b0, tx);
    wait_idle();
    chk("single_highs", hi_a - s_hi, 136);
    chk("single_busy_cycles", busy_n - s_busy, 1080);
    chk("single_frame_done_count", fd_n - s_fd, 1);
    chk("single_frame_done_time", fd_cyc - tx, 1080);
    step(5);

    s_hi = hi_a; s_busy = busy_n;
    send(48'h000001, 1'b0, 1'b1, tx);
    send(48'h800000, 1'b1, 1'b0, tx2);
    wait_idle();
    chk("b2b_seam", tx2 - tx, 360);
    chk("b2b_highs", hi_a - s_hi, 202);
    chk("b2b_busy_cycles", busy_n - s_busy, 1440);
    chk("b2b_frame_done_time", fd_cyc - tx, 1440);
    step(5);

    s_busy = busy_n; s_ur = ur_n;
    send(48'h000001, 1'b0, 1'b0, tx);
    step(459);
    send(48'h800000, 1'b1, 1'b0, tx2);
    wait_idle();
    chk("stall_accept_gap", tx2 - tx, 460);
    chk("stall_busy_cycles", busy_n - s_busy, 1540);
    chk("stall_frame_done_time", fd_cyc - tx, 1540);
    chk("stall_no_underrun", ur_n - s_ur, 0);
    step(5);

    s_busy = busy_n; s_ur = ur_n; s_fd = fd_n;
    send(48'h000000, 1'b0, 1'b0, tx);
    wait_idle();
    chk("timeout_underrun_count", ur_n - s_ur, 1);
    chk("timeout_underrun_time", ur_cyc - tx, 1081);
    chk("timeout_no_frame_done", fd_n - s_fd, 0);
    chk("timeout_busy_cycles", busy_n - s_busy, 1080);
    step(5);

    s_ur = ur_n; s_fd = fd_n;
    send(48'h00000F, 1'b0, 1'b0, tx);
    step(1079);
    send(48'hF00000, 1'b1, 1'b0, tx2);
    wait_idle();
    chk("tie_accept_gap", tx2 - tx, 1080);
    chk("tie_no_underrun", ur_n - s_ur, 0);
    chk("tie_frame_done_count", fd_n - s_fd, 1);
    chk("tie_frame_done_time", fd_cyc - tx2, 1080);
    step(5);

    send(48'h000000_FF0000, 1'b1, 1'b0, tx);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_dout1", int'(d1), 0);
    chk("midreset_busy1", int'(busy1), 0);
    chk("midreset_dout2", int'(d2), 0);
    chk("midreset_busy2", int'(busy2), 0);
    step(3);
    rst_n = 1'b1;
    step(3);
    s_hi = hi_a; s_fd = fd_n;
    send(48'h000000_0F0F0F, 1'b1, 1'b0, tx);
    wait_idle();
    chk("postreset_highs", hi_a - s_hi, 156);
    chk("postreset_frame_done_count", fd_n - s_fd, 1);
    chk("postreset_frame_done_time", fd_cyc - tx, 1080);
    step(5);

    s_hi = hi_a; s_b0 = hi_b0; s_b1 = hi_b1;
    send({24'h00FF00, 24'hAAAAAA}, 1'b1, 1'b0, tx);
    wait_idle();
    chk("multi_ch1_highs", hi_b1 - s_b1, 136);
    chk("multi_ch0_highs", hi_b0 - s_b0, 156);
    chk("multi_single_inst_highs", hi_a - s_hi, 156);
    chk("multi_frame_done_time", fd_cyc - tx, 1080);
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
